// File: rtl/dual_demux_capture.sv
// dual_demux_capture: clocked dual 1-to-4 demultiplexer with per-lane
// 4-bit capture registers. This is the inverse of a dual 4-to-1 selector.
// Each lane steers one data bit into q[sel]. The select comes either from
// the external {b,a} address (mode=0) or from a shared auto-incrementing
// pointer (mode=1). In sequential mode, frame pulses mark a completed nibble.
module dual_demux_capture (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear_n,
    input  logic       mode,
    input  logic       a,
    input  logic       b,
    input  logic       enable1_n,
    input  logic       enable2_n,
    input  logic       d1,
    input  logic       d2,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [1:0] idx,
    output logic       frame1,
    output logic       frame2
);

    logic [1:0] sel;
    logic       lane1_we;
    logic       lane2_we;
    logic       any_we;
    logic       last_slot;

    assign lane1_we  = ~enable1_n;
    assign lane2_we  = ~enable2_n;
    assign any_we    = lane1_we | lane2_we;
    // The nibble completes on the edge that writes position 3 in sequential mode.
    assign last_slot = mode & (idx == 2'd3);

    // Choose the write position: the external address or the shared pointer.
    always_comb begin
        // NOTE: assign a default first so that no path through the block leaves sel unassigned (which would infer a latch).
        sel = {b, a};
        if (mode) begin
            sel = idx;
        end
    end

    // Capture registers, pointer and frame pulses. Priority is reset, then clear, then writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these are a few flops rather than a memory array, so every bit gets an asynchronous reset value.
            q1     <= 4'b0000;
            q2     <= 4'b0000;
            idx    <= 2'd0;
            frame1 <= 1'b0;
            frame2 <= 1'b0;
        end else if (!clear_n) begin
            q1     <= 4'b0000;
            q2     <= 4'b0000;
            idx    <= 2'd0;
            frame1 <= 1'b0;
            frame2 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so idx and sel are read as their pre-edge values throughout this block.
            if (lane1_we) begin
                q1[sel] <= d1;
            end
            if (lane2_we) begin
                q2[sel] <= d2;
            end
            // Both lanes share one pointer. It advances on any enabled write in sequential mode and wraps 3->0.
            if (mode && any_we) begin
                idx <= idx + 2'd1;
            end
            // A frame is only ever a one-cycle pulse. It is low in addressed mode and on idle edges.
            frame1 <= last_slot & lane1_we;
            frame2 <= last_slot & lane2_we;
        end
    end

endmodule

// File: tb/tb_dual_demux_capture.sv
// Self-checking bench for dual_demux_capture. The bench is built from four parts:
// - a reset check that runs after random addressed writes;
// - a table of single-edge vectors with hand-derived expected outputs;
// - a round-trip stream, in which a 74x153 model reading q with the
//   previous-cycle select must reproduce the serial input bits;
// - a scoreboard queue that carries expected results from drive time to check time.
module tb_dual_demux_capture;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_n = 1'b1;
    logic       mode = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       enable1_n = 1'b1;
    logic       enable2_n = 1'b1;
    logic       d1 = 1'b0;
    logic       d2 = 1'b0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [1:0] idx;
    logic       frame1;
    logic       frame2;

    int total = 0;
    int bad   = 0;

    dual_demux_capture dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_n   (clear_n),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .enable1_n (enable1_n),
        .enable2_n (enable2_n),
        .d1        (d1),
        .d2        (d2),
        .q1        (q1),
        .q2        (q2),
        .idx       (idx),
        .frame1    (frame1),
        .frame2    (frame2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr_n;
        logic       mode;
        logic       b;
        logic       a;
        logic       e1_n;
        logic       e2_n;
        logic       d1;
        logic       d2;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [1:0] idx;
        logic       f1;
        logic       f2;
    } vec_t;

    typedef struct {
        logic       d1;
        logic       d2;
        logic [1:0] sel;
    } rt_t;

    localparam int NV = 24;
    vec_t vecs[NV];
    vec_t exp_q[$];
    rt_t  rt_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr_n, input logic md, input logic bb, input logic aa,
                                input logic e1, input logic e2, input logic dd1, input logic dd2,
                                input logic [3:0] eq1, input logic [3:0] eq2, input logic [1:0] ei,
                                input logic ef1, input logic ef2);
        vec_t v;
        v.clr_n = clr_n; v.mode = md; v.b = bb; v.a = aa;
        v.e1_n = e1; v.e2_n = e2; v.d1 = dd1; v.d2 = dd2;
        v.q1 = eq1; v.q2 = eq2; v.idx = ei; v.f1 = ef1; v.f2 = ef2;
        return v;
    endfunction

    // 74x153 model: one lane of the selector.
    function automatic logic mux153(input logic [3:0] c, input logic [1:0] s);
        return c[s];
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        clear_n = v.clr_n; mode = v.mode; b = v.b; a = v.a;
        enable1_n = v.e1_n; enable2_n = v.e2_n; d1 = v.d1; d2 = v.d2;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " q1"}, {4'd0, q1}, {4'd0, e.q1});
            check({tag, " q2"}, {4'd0, q2}, {4'd0, e.q2});
            check({tag, " idx"}, {6'd0, idx}, {6'd0, e.idx});
            check({tag, " frame1"}, {7'd0, frame1}, {7'd0, e.f1});
            check({tag, " frame2"}, {7'd0, frame2}, {7'd0, e.f2});
        end
    endtask

    task automatic idle_inputs();
        clear_n = 1'b1; enable1_n = 1'b1; enable2_n = 1'b1; d1 = 1'b0; d2 = 1'b0;
    endtask

    initial begin
        logic [3:0] r1;
        logic [3:0] r2;
        logic [1:0] ptr;
        rt_t        rt;

        // Addressed-mode writes, including a hold on both lanes.
        //             clr md b a e1 e2 d1 d2  q1       q2       idx  f1 f2
        vecs[0]  = mk(1, 0, 1, 0, 0, 1, 1, 1, 4'b0100, 4'b0000, 2'd0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 4'b0101, 4'b0000, 2'd0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 1, 1, 1, 1, 4'b0101, 4'b0000, 2'd0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Sequential mode: d1 = 1,0,1,1 and d2 = 0,1,1,0, with frames after the 4th edge.
        vecs[4]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 4'b0000, 2'd1, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 4'b0001, 4'b0010, 2'd2, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 4'b0101, 4'b0110, 2'd3, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 4'b1101, 4'b0110, 2'd0, 1, 1);
        vecs[8]  = mk(1, 1, 0, 0, 1, 1, 1, 1, 4'b1101, 4'b0110, 2'd0, 0, 0);
        // Hold/gap: two writes, two idle edges, then two more writes.
        vecs[9]  = mk(0, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        vecs[10] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 2'd1, 0, 0);
        vecs[11] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0011, 4'b0000, 2'd2, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 1, 1, 1, 1, 4'b0011, 4'b0000, 2'd2, 0, 0);
        vecs[13] = mk(1, 1, 1, 1, 1, 1, 1, 1, 4'b0011, 4'b0000, 2'd2, 0, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 1, 0, 0, 4'b0011, 4'b0000, 2'd3, 0, 0);
        vecs[15] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b1011, 4'b0000, 2'd0, 1, 0);
        vecs[16] = mk(1, 1, 0, 0, 1, 1, 0, 0, 4'b1011, 4'b0000, 2'd0, 0, 0);
        // Clear priority: only lane 2 advances the pointer to 3, then clear arrives with lane 1 enabled.
        vecs[17] = mk(1, 1, 0, 0, 1, 0, 0, 1, 4'b1011, 4'b0001, 2'd1, 0, 0);
        vecs[18] = mk(1, 1, 0, 0, 1, 0, 0, 0, 4'b1011, 4'b0001, 2'd2, 0, 0);
        vecs[19] = mk(1, 1, 0, 0, 1, 0, 0, 1, 4'b1011, 4'b0101, 2'd3, 0, 0);
        vecs[20] = mk(0, 1, 0, 0, 0, 1, 1, 1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Mode switch mid-nibble: the pointer is retained while addressed writes occur.
        vecs[21] = mk(1, 1, 0, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 2'd1, 0, 0);
        vecs[22] = mk(1, 0, 1, 1, 0, 1, 1, 0, 4'b1001, 4'b0000, 2'd1, 0, 0);
        vecs[23] = mk(1, 1, 1, 1, 0, 1, 1, 0, 4'b1011, 4'b0000, 2'd2, 0, 0);

        // Reset release, then write random nibbles in addressed mode.
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        r1 = 4'($urandom_range(1, 15));
        r2 = 4'($urandom_range(1, 15));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mode = 1'b0; {b, a} = 2'(k);
            enable1_n = 1'b0; enable2_n = 1'b0; d1 = r1[k]; d2 = r2[k];
        end
        @(negedge clk);
        idle_inputs();
        check("pre_reset q1", {4'd0, q1}, {4'd0, r1});
        check("pre_reset q2", {4'd0, q2}, {4'd0, r2});

        // Reset is pulsed between edges; the outputs must clear without a clock edge.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset q1", {4'd0, q1}, 8'd0);
        check("async_reset q2", {4'd0, q2}, 8'd0);
        check("async_reset idx", {6'd0, idx}, 8'd0);
        check("async_reset frames", {6'd0, frame1, frame2}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Round trip: 32 random bits per lane in sequential mode, starting from a cleared state.
        apply_vec(mk(0, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0), "rt_clear");
        ptr = 2'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            clear_n = 1'b1; mode = 1'b1; enable1_n = 1'b0; enable2_n = 1'b0;
            d1 = 1'($urandom); d2 = 1'($urandom);
            rt.d1 = d1; rt.d2 = d2; rt.sel = ptr;
            rt_q.push_back(rt);
            ptr = ptr + 2'd1;
            @(posedge clk);
            #1;
            if (rt_q.size() == 0) begin
                check("rt scoreboard_empty", 8'd1, 8'd0);
            end else begin
                rt = rt_q.pop_front();
                check($sformatf("rt%0d lane1", i), {7'd0, mux153(q1, rt.sel)}, {7'd0, rt.d1});
                check($sformatf("rt%0d lane2", i), {7'd0, mux153(q2, rt.sel)}, {7'd0, rt.d2});
                check($sformatf("rt%0d idx", i), {6'd0, idx}, {6'd0, ptr});
                check($sformatf("rt%0d frames", i), {6'd0, frame1, frame2},
                      (rt.sel == 2'd3) ? 8'd3 : 8'd0);
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
